// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with optional write-to-read
// bypass, a per-register busy scoreboard and a committed-state debug read port.
module regfile_mp #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NRP    = 2,
  parameter int unsigned NWP    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWP-1:0]      i_we,
  input  logic [NWP*AW-1:0]   i_waddr,
  input  logic [NWP*XLEN-1:0] i_wdata,
  input  logic [NRP-1:0]      i_re,
  input  logic [NRP*AW-1:0]   i_raddr,
  output logic [NRP*XLEN-1:0] o_rdata,
  output logic [NRP-1:0]      o_rbusy,
  input  logic                i_sb_set,
  input  logic [AW-1:0]       i_sb_addr,
  input  logic                i_sb_flush,
  input  logic [AW-1:0]       i_dbg_addr,
  output logic [XLEN-1:0]     o_dbg_data
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;

  logic [NREG-1:0] w_busy_d;
  logic [AW-1:0]   w_raddr [NRP];
  logic [NRP-1:0]  w_hit;
  logic [XLEN-1:0] w_fwd   [NRP];

  // Register array update; ascending port order lets the highest-index writer win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NWP; k++) begin
        if (i_we[k] && (i_waddr[k*AW +: AW] != '0)) begin
          r_regs[i_waddr[k*AW +: AW]] <= i_wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: later assignments carry higher priority (flush > set > writeback).
  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned k = 0; k < NWP; k++) begin
      if (i_we[k]) begin
        w_busy_d[i_waddr[k*AW +: AW]] = 1'b0;
      end
    end
    if (i_sb_set) begin
      w_busy_d[i_sb_addr] = 1'b1;
    end
    if (i_sb_flush) begin
      w_busy_d = '0;
    end
    w_busy_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  // Read ports: forwarding match search plus priority-gated data and busy outputs.
  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    w_hit   = '0;
    for (int unsigned i = 0; i < NRP; i++) begin
      w_raddr[i] = i_raddr[i*AW +: AW];
      w_fwd[i]   = '0;
      for (int unsigned k = 0; k < NWP; k++) begin
        if (i_we[k] && (i_waddr[k*AW +: AW] == w_raddr[i])) begin
          w_hit[i] = 1'b1;
          w_fwd[i] = i_wdata[k*XLEN +: XLEN];
        end
      end
      if (!rst && i_re[i] && (w_raddr[i] != '0)) begin
        if ((BYPASS != 0) && w_hit[i]) begin
          o_rdata[i*XLEN +: XLEN] = w_fwd[i];
        end else begin
          o_rdata[i*XLEN +: XLEN] = r_regs[w_raddr[i]];
        end
        // Forwarded data is by definition the pending result, so it is not busy.
        o_rbusy[i] = r_busy[w_raddr[i]] && !((BYPASS != 0) && w_hit[i]);
      end
    end
  end

  // Debug port sees committed state only.
  always_comb begin
    o_dbg_data = '0;
    if (!rst && (i_dbg_addr != '0)) begin
      o_dbg_data = r_regs[i_dbg_addr];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a behavioural model.
module tb_regfile_mp;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRP  = 2;
  localparam int unsigned NWP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NWP-1:0]      we;
  logic [NWP*AW-1:0]   waddr;
  logic [NWP*XLEN-1:0] wdata;
  logic [NRP-1:0]      re;
  logic [NRP*AW-1:0]   raddr;
  logic                sb_set, sb_flush;
  logic [AW-1:0]       sb_addr, dbg_addr;

  logic [NRP*XLEN-1:0] rdata_a, rdata_b;
  logic [NRP-1:0]      rbusy_a, rbusy_b;
  logic [XLEN-1:0]     dbg_a, dbg_b;

  // Narrow sweep instance: XLEN=32, three read ports, one write port.
  logic        c_we;
  logic [4:0]  c_waddr;
  logic [31:0] c_wdata;
  logic [2:0]  c_re;
  logic [14:0] c_raddr;
  logic [95:0] c_rdata;
  logic [2:0]  c_rbusy;
  logic        c_sb_set, c_sb_flush;
  logic [4:0]  c_sb_addr, c_dbg_addr;
  logic [31:0] c_dbg;

  regfile_mp #(.XLEN(64), .NREG(32), .AW(5), .NRP(2), .NWP(2), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_re(re),
    .i_raddr(raddr), .o_rdata(rdata_a), .o_rbusy(rbusy_a), .i_sb_set(sb_set),
    .i_sb_addr(sb_addr), .i_sb_flush(sb_flush), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_a)
  );

  regfile_mp #(.XLEN(64), .NREG(32), .AW(5), .NRP(2), .NWP(2), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_re(re),
    .i_raddr(raddr), .o_rdata(rdata_b), .o_rbusy(rbusy_b), .i_sb_set(sb_set),
    .i_sb_addr(sb_addr), .i_sb_flush(sb_flush), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_b)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRP(3), .NWP(1), .BYPASS(1)) u_dut_c (
    .clk(clk), .rst(rst), .i_we(c_we), .i_waddr(c_waddr), .i_wdata(c_wdata), .i_re(c_re),
    .i_raddr(c_raddr), .o_rdata(c_rdata), .o_rbusy(c_rbusy), .i_sb_set(c_sb_set),
    .i_sb_addr(c_sb_addr), .i_sb_flush(c_sb_flush), .i_dbg_addr(c_dbg_addr),
    .o_dbg_data(c_dbg)
  );

  // Reference model of committed state, shared by the BYPASS=1 and BYPASS=0 instances.
  logic [63:0] m_regs [32];
  bit          m_busy [32];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] exp_rdata(input bit byp, input int i);
    logic [AW-1:0] a;
    logic [63:0]   v;
    a = raddr[i*AW +: AW];
    if (rst || !re[i] || a == 0) return '0;
    v = m_regs[a];
    if (byp) begin
      for (int k = 0; k < NWP; k++)
        if (we[k] && waddr[k*AW +: AW] == a) v = wdata[k*XLEN +: XLEN];
    end
    return v;
  endfunction

  function automatic bit exp_rbusy(input bit byp, input int i);
    logic [AW-1:0] a;
    a = raddr[i*AW +: AW];
    if (rst || !re[i] || a == 0) return 1'b0;
    if (byp) begin
      for (int k = 0; k < NWP; k++)
        if (we[k] && waddr[k*AW +: AW] == a) return 1'b0;
    end
    return m_busy[a];
  endfunction

  function automatic logic [63:0] exp_dbg();
    if (rst) return '0;
    return m_regs[dbg_addr];
  endfunction

  task automatic model_update();
    bit wr_hit [32];
    logic [AW-1:0] a;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 0; r < 32; r++) wr_hit[r] = 1'b0;
      for (int k = 0; k < NWP; k++) begin
        a = waddr[k*AW +: AW];
        if (we[k]) begin
          wr_hit[a] = 1'b1;
          if (a != 0) m_regs[a] = wdata[k*XLEN +: XLEN];
        end
      end
      for (int r = 1; r < 32; r++) begin
        if (sb_flush) m_busy[r] = 1'b0;
        else if (sb_set && sb_addr == r) m_busy[r] = 1'b1;
        else if (wr_hit[r]) m_busy[r] = 1'b0;
      end
    end
  endtask

  // Let combinational outputs settle, then compare both 64-bit instances with the model.
  task automatic settle();
    #1;
    for (int i = 0; i < NRP; i++) begin
      check($sformatf("A.rdata%0d", i), rdata_a[i*XLEN +: XLEN], exp_rdata(1'b1, i));
      check($sformatf("A.rbusy%0d", i), 64'(rbusy_a[i]), 64'(exp_rbusy(1'b1, i)));
      check($sformatf("B.rdata%0d", i), rdata_b[i*XLEN +: XLEN], exp_rdata(1'b0, i));
      check($sformatf("B.rbusy%0d", i), 64'(rbusy_b[i]), 64'(exp_rbusy(1'b0, i)));
    end
    check("A.dbg", dbg_a, exp_dbg());
    check("B.dbg", dbg_b, exp_dbg());
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    sb_set = 1'b0; sb_flush = 1'b0; sb_addr = '0; dbg_addr = '0;
    c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_re = '0; c_raddr = '0;
    c_sb_set = 1'b0; c_sb_flush = 1'b0; c_sb_addr = '0; c_dbg_addr = '0;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  logic [31:0] c_vals [4];

  initial begin
    idle();
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;

    // Reset clears state written earlier.
    idle(); we = 2'b01; waddr[4:0] = 5'd5; wdata[63:0] = 64'hDEAD_BEEF; settle(); tick();
    idle(); re = 2'b01; raddr[4:0] = 5'd5; dbg_addr = 5'd5; settle();
    check("x5.written", rdata_a[63:0], 64'hDEAD_BEEF);
    tick();
    rst = 1'b1; re = 2'b11; raddr = {5'd5, 5'd5}; settle();
    check("rst.lane0", rdata_a[63:0], 64'h0);
    check("rst.lane1", rdata_a[127:64], 64'h0);
    tick();
    rst = 1'b0; re = 2'b01; raddr = {5'd0, 5'd5}; dbg_addr = 5'd5; settle();
    check("x5.after_rst", rdata_a[63:0], 64'h0);
    check("x5.rbusy_after_rst", 64'(rbusy_a), 64'h0);
    check("x5.dbg_after_rst", dbg_a, 64'h0);
    tick();

    // x0 is hardwired to zero, also on the forwarding path.
    idle(); we = 2'b01; waddr[4:0] = 5'd0; wdata[63:0] = 64'h1234;
    re = 2'b11; raddr = {5'd0, 5'd0}; settle();
    check("x0.bypass", rdata_a[63:0], 64'h0);
    tick();
    idle(); re = 2'b11; settle();
    check("x0.read0", rdata_a[63:0], 64'h0);
    check("x0.read1", rdata_a[127:64], 64'h0);
    tick();

    // Same-address write conflict: highest port wins, forwarded only with BYPASS=1.
    idle(); we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {64'h22, 64'h11};
    re = 2'b01; raddr[4:0] = 5'd7; settle();
    check("x7.bypass", rdata_a[63:0], 64'h22);
    check("x7.nobypass", rdata_b[63:0], 64'h0);
    tick();
    idle(); re = 2'b01; raddr[4:0] = 5'd7; settle();
    check("x7.regs_a", rdata_a[63:0], 64'h22);
    check("x7.regs_b", rdata_b[63:0], 64'h22);
    tick();

    // Scoreboard life-cycle on x3.
    idle(); sb_set = 1'b1; sb_addr = 5'd3; re = 2'b01; raddr[4:0] = 5'd3; settle();
    check("x3.set_same_cycle", 64'(rbusy_a[0]), 64'h0);
    tick();
    idle(); re = 2'b01; raddr[4:0] = 5'd3; settle();
    check("x3.busy_a", 64'(rbusy_a[0]), 64'h1);
    check("x3.busy_b", 64'(rbusy_b[0]), 64'h1);
    we = 2'b01; waddr[4:0] = 5'd3; wdata[63:0] = 64'h55; settle();
    check("x3.wb_busy_a", 64'(rbusy_a[0]), 64'h0);
    check("x3.wb_data_a", rdata_a[63:0], 64'h55);
    check("x3.wb_busy_b", 64'(rbusy_b[0]), 64'h1);
    tick();
    idle(); re = 2'b01; raddr[4:0] = 5'd3; settle();
    check("x3.after_wb_busy", 64'(rbusy_a[0]), 64'h0);
    check("x3.after_wb_data", rdata_a[63:0], 64'h55);
    tick();

    // Set beats writeback.
    idle(); sb_set = 1'b1; sb_addr = 5'd9; we = 2'b01; waddr[4:0] = 5'd9;
    wdata[63:0] = 64'h99; settle(); tick();
    idle(); re = 2'b01; raddr[4:0] = 5'd9; dbg_addr = 5'd9; settle();
    check("x9.busy", 64'(rbusy_a[0]), 64'h1);
    check("x9.data", rdata_a[63:0], 64'h99);
    check("x9.dbg", dbg_a, 64'h99);
    tick();

    // Flush beats set.
    idle(); sb_set = 1'b1; sb_addr = 5'd4; sb_flush = 1'b1; settle(); tick();
    idle(); re = 2'b01; raddr[4:0] = 5'd4; settle();
    check("x4.flush_wins", 64'(rbusy_a[0]), 64'h0);
    tick();

    // Flush clears several busy bits without touching contents.
    idle(); we = 2'b11; waddr = {5'd2, 5'd1}; wdata = {64'h202, 64'h101}; settle(); tick();
    idle(); sb_set = 1'b1; sb_addr = 5'd1; settle(); tick();
    idle(); sb_set = 1'b1; sb_addr = 5'd2; settle(); tick();
    idle(); sb_set = 1'b1; sb_addr = 5'd30; we = 2'b10; waddr[9:5] = 5'd30;
    wdata[127:64] = 64'h3030; settle(); tick();
    idle(); re = 2'b11; raddr = {5'd2, 5'd1}; dbg_addr = 5'd30; settle();
    check("x1x2.busy", 64'(rbusy_a), 64'h3);
    check("x30.dbg", dbg_a, 64'h3030);
    sb_flush = 1'b1; settle(); tick();
    idle(); re = 2'b11; raddr = {5'd30, 5'd1}; settle();
    check("flush.busy", 64'(rbusy_a), 64'h0);
    check("flush.x1", rdata_a[63:0], 64'h101);
    check("flush.x30", rdata_a[127:64], 64'h3030);
    raddr = {5'd2, 5'd1}; settle();
    check("flush.x2", rdata_a[127:64], 64'h202);
    tick();

    // Reset discards same-cycle write and scoreboard set.
    idle(); rst = 1'b1; we = 2'b01; waddr[4:0] = 5'd6; wdata[63:0] = 64'h66;
    sb_set = 1'b1; sb_addr = 5'd6; settle(); tick();
    rst = 1'b0; idle(); re = 2'b01; raddr[4:0] = 5'd6; settle();
    check("x6.rst_write", rdata_a[63:0], 64'h0);
    check("x6.rst_busy", 64'(rbusy_a[0]), 64'h0);
    tick();

    // Narrow sweep instance: three reads plus debug in one cycle.
    c_vals[0] = 32'hA0A0_0010; c_vals[1] = 32'hB1B1_0011;
    c_vals[2] = 32'hC2C2_0012; c_vals[3] = 32'hD3D3_0013;
    for (int n = 0; n < 4; n++) begin
      idle(); c_we = 1'b1; c_waddr = 5'(10 + n); c_wdata = c_vals[n]; settle(); tick();
    end
    idle(); c_sb_set = 1'b1; c_sb_addr = 5'd11; settle(); tick();
    idle(); c_re = 3'b111; c_raddr = {5'd12, 5'd11, 5'd10}; c_dbg_addr = 5'd13; settle();
    for (int n = 0; n < 3; n++) check($sformatf("C.rdata%0d", n), 64'(c_rdata[n*32 +: 32]),
                                      64'(c_vals[n]));
    check("C.dbg", 64'(c_dbg), 64'(c_vals[3]));
    check("C.rbusy", 64'(c_rbusy), 64'h2);
    c_we = 1'b1; c_waddr = 5'd12; c_wdata = 32'h0000_5A5A; settle();
    check("C.bypass", 64'(c_rdata[95:64]), 64'h5A5A);
    check("C.rd0_kept", 64'(c_rdata[31:0]), 64'(c_vals[0]));
    tick();

    // Randomized traffic biased toward a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      we  = 2'($urandom);
      for (int k = 0; k < NWP; k++) begin
        waddr[k*AW +: AW]     = pick_addr();
        wdata[k*XLEN +: XLEN] = {$urandom, $urandom};
      end
      re = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      for (int i = 0; i < NRP; i++) raddr[i*AW +: AW] = pick_addr();
      sb_set   = ($urandom_range(0, 3) == 0);
      sb_addr  = pick_addr();
      sb_flush = ($urandom_range(0, 19) == 0);
      dbg_addr = pick_addr();
      settle();
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the NPC core. Successor to the single-write/two-read register file.
- Configurable width, depth, read-port count and write-port count, with optional write-to-read bypass.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback, flushable) and a debug read port for difftest.
- Sits between decode/issue (reads, busy checks) and writeback (writes).

Parameters:
XLEN, 64, data width of each register in bits
NREG, 32, number of registers (power of two)
AW, 5, register address width; must equal log2(NREG)
NRP, 2, number of read ports
NWP, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
we  input  NWP  write enable per write port
waddr  input  NWP*AW  write addresses; port k occupies bits [k*AW +: AW]
wdata  input  NWP*XLEN  write data; port k occupies bits [k*XLEN +: XLEN]
re  input  NRP  read enable per read port
raddr  input  NRP*AW  read addresses, packed the same way as waddr
rdata  output  NRP*XLEN  read data, combinational
rbusy  output  NRP  1 = the addressed register has a pending producer
sb_set  input  1  mark sb_addr busy (instruction issued with destination sb_addr)
sb_addr  input  AW  destination register to mark busy
sb_flush  input  1  clear all busy bits
dbg_addr  input  AW  debug/difftest read address
dbg_data  output  XLEN  debug read data; combinational, never bypassed

Behaviour:
- Reset:
  - While rst=1 at posedge, all registers and all busy bits become 0 on that edge.
  - While rst=1, every rdata lane, every rbusy bit and dbg_data are forced to 0.
  - Reset asserted mid-operation discards same-cycle writes, sb_set and sb_flush.
- Register 0:
  - Hardwired to zero; writes to it are ignored.
  - A read of address 0 returns 0 and rbusy=0.
  - Register 0 is never marked busy.
- Writes:
  - At posedge, for each port k with we[k]=1 and waddr[k]!=0, regs[waddr[k]] <= wdata[k]. Result is visible from regs on the next cycle.
  - Several ports writing the same address in one cycle: the highest-index port wins.
  - Different addresses are written independently in the same cycle.
- Read port i (combinational, priority order):
  - rst=1 -> 0.
  - re[i]=0 -> 0.
  - raddr[i]=0 -> 0.
  - BYPASS=1 and some k has we[k]=1 and waddr[k]==raddr[i] -> wdata of the highest matching k.
  - Otherwise -> regs[raddr[i]].
- Scoreboard, per register r!=0, next state of busy[r] in priority order:
  - rst -> 0.
  - sb_flush -> 0. Flush beats a same-cycle sb_set, because the issuing instruction is squashed.
  - sb_set and sb_addr==r -> 1. Set beats a same-cycle writeback to r, because a new producer supersedes the old one.
  - Any k with we[k]=1 and waddr[k]==r -> 0.
  - Otherwise hold.
- rbusy[i]:
  - Equals re[i] & (raddr[i]!=0) & busy[raddr[i]].
  - When BYPASS=1, it is additionally suppressed if a same-cycle write matches raddr[i], since the data is being forwarded.
  - A same-cycle sb_set never affects rbusy; busy is visible from the next cycle.
- dbg_data: regs[dbg_addr] (0 for address 0), reflecting committed state only.
- Out-of-range addresses cannot occur because NREG=2^AW.

Test Plan:
- Reset clears state: write 0xDEAD_BEEF to x5, then assert rst for 1 cycle -> next cycle a read of x5 returns 0, rbusy=0 and dbg_data(x5)=0. During the rst cycle all rdata lanes are 0.
- x0 is hardwired: we[0]=1, waddr=0, wdata=0x1234; then read x0 on both ports -> rdata=0. With BYPASS=1, the same-cycle read of x0 also returns 0.
- Write conflict and bypass: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle, with read port 0 on x7:
  - same cycle with BYPASS=1 -> 0x22;
  - next cycle -> 0x22 from regs;
  - with BYPASS=0, the same-cycle read returns the old value 0.
- Scoreboard life-cycle: sb_set on x3 -> the next-cycle read of x3 shows rbusy=1. A write to x3 of 0x55 (BYPASS=1) in that cycle gives rbusy=0 and rdata=0x55 that cycle, and busy stays 0 afterwards.
- Simultaneous events:
  - sb_set on x9 together with a write to x9 -> x9 is busy next cycle and regs[x9] is updated.
  - sb_set on x4 together with sb_flush -> x4 is not busy next cycle.
  - Flush with busy x1, x2, x30 set -> all clear next cycle, register contents unchanged.
- Parameter sweep: NRP=3, NWP=1, XLEN=32, then read three distinct registers plus dbg_addr in one cycle -> all four values match the written values.
